// File: rtl/width_packer_pkg.sv
// Shared definitions for the serial packer/serializer family: handshake levels,
// parameter legality check and counter-width helpers.
package width_packer_pkg;

    // Active levels of the put/free handshake used on every serial-path stream.
    localparam bit HS_PUT  = 1'b1;
    localparam bit HS_FREE = 1'b1;

    // Ceiling log2, valid for n >= 1; used for lane counters sized to hold 0..RATIO.
    function automatic int clog2_ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Wide word must be an exact multiple (at least two) of the lane width.
    function automatic bit ratio_ok(input int in_w, input int out_w);
        if (in_w < 1) begin
            return 1'b0;
        end
        return ((out_w % in_w) == 0) && ((out_w / in_w) >= 2);
    endfunction

    // Width of a lane counter that must represent 0..RATIO inclusive.
    function automatic int count_width(input int in_w, input int out_w);
        if (in_w < 1) begin
            return 1;
        end
        return clog2_ceil((out_w / in_w) + 1);
    endfunction

endpackage

// File: rtl/width_packer_out_reg.sv
// Single-entry output holding register with put/free handshake; a new word may be
// loaded on the same edge the held word is consumed.
module width_packer_out_reg
    import width_packer_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [CW-1:0] load_count,
    input  logic          free,
    output logic          put,
    output logic [DW-1:0] data,
    output logic [CW-1:0] count,
    output logic          slot_ok
);

    logic          valid_reg;
    logic [DW-1:0] data_reg;
    logic [CW-1:0] count_reg;

    // Slot is usable when empty or when the held word leaves on this edge.
    assign slot_ok = (valid_reg != HS_PUT) || (free == HS_FREE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            count_reg <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            count_reg <= load_count;
        end else if (valid_reg && free) begin
            valid_reg <= 1'b0;
        end
    end

    assign put   = valid_reg;
    assign data  = data_reg;
    assign count = count_reg;

endmodule

// File: rtl/width_packer.sv
// Narrow-to-wide deserializer: packs INPUT_WIDTH-bit lanes LSB-first into
// OUTPUT_WIDTH-bit words, with flush for partial words and a one-word output buffer.
module width_packer
    import width_packer_pkg::*;
#(
    parameter int  INPUT_WIDTH  = 1,
    parameter int  OUTPUT_WIDTH = 8,
    localparam int RATIO        = (INPUT_WIDTH >= 1) ? (OUTPUT_WIDTH / INPUT_WIDTH) : 2,
    localparam int CW           = count_width(INPUT_WIDTH, OUTPUT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_in_put,
    output logic                    data_in_free,
    input  logic [INPUT_WIDTH-1:0]  data_in,
    input  logic                    flush,
    output logic                    data_out_put,
    input  logic                    data_out_free,
    output logic [OUTPUT_WIDTH-1:0] data_out,
    output logic [CW-1:0]           data_out_count
);

    if (!ratio_ok(INPUT_WIDTH, OUTPUT_WIDTH)) begin : g_bad_params
        $error("width_packer: OUTPUT_WIDTH must be a multiple (>= 2x) of INPUT_WIDTH");
    end

    localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);

    logic [OUTPUT_WIDTH-1:0] acc_reg;
    logic [OUTPUT_WIDTH-1:0] acc_merged;
    logic [CW-1:0]           cnt_reg;
    logic [CW-1:0]           cnt_merged;
    logic                    flush_pend_reg;
    logic                    in_xfer;
    logic                    full;
    logic                    flush_eff;
    logic                    emit;
    logic                    slot_ok;

    // Depends on packer state only, so downstream free never reaches upstream free.
    assign data_in_free = (cnt_reg != CNT_FULL) && !flush_pend_reg;
    assign in_xfer      = data_in_put && data_in_free;
    assign cnt_merged   = cnt_reg + CW'(in_xfer);
    assign full         = (cnt_merged == CNT_FULL);

    // A flush only counts when there is at least one lane to emit.
    assign flush_eff = flush_pend_reg || (flush && ((cnt_reg != '0) || in_xfer));
    assign emit      = (full || flush_eff) && slot_ok;

    // Accumulator view including this cycle's accepted lane.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        assign acc_merged[gi*INPUT_WIDTH +: INPUT_WIDTH] =
            (in_xfer && (cnt_reg == CW'(gi))) ? data_in
                                              : acc_reg[gi*INPUT_WIDTH +: INPUT_WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg        <= '0;
            cnt_reg        <= '0;
            flush_pend_reg <= 1'b0;
        end else if (emit) begin
            acc_reg        <= '0;
            cnt_reg        <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            acc_reg        <= acc_merged;
            cnt_reg        <= cnt_merged;
            // A flush landing on a completed word is just a full word.
            flush_pend_reg <= flush_eff && !full;
        end
    end

    width_packer_out_reg #(
        .DW (OUTPUT_WIDTH),
        .CW (CW)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (emit),
        .load_data  (acc_merged),
        .load_count (cnt_merged),
        .free       (data_out_free),
        .put        (data_out_put),
        .data       (data_out),
        .count      (data_out_count),
        .slot_ok    (slot_ok)
    );

endmodule

// File: doc/width_packer.md
Name: width_packer

Overview:
- Narrow-to-wide deserializer. Collects INPUT_WIDTH-bit lanes into OUTPUT_WIDTH-bit words, LSB-first.
- Inverse of the existing wide-to-narrow serializer. It sits on the receive side of serial paths, for example between the bit-level receiver and byte-wide consumers.
- Provides a one-word output holding register, so accumulation continues while a completed word waits.
- Provides a flush input to emit a partial word.

Parameters:
- INPUT_WIDTH, 1: lane width in bits. Must be ≥ 1.
- OUTPUT_WIDTH, 8: word width in bits. Must be an integer multiple of INPUT_WIDTH, ratio ≥ 2. Violations must raise an elaboration-time error.
- Derived RATIO = OUTPUT_WIDTH/INPUT_WIDTH.
- Derived CW = $clog2(RATIO+1).

Ports:
- clk  in  1  sole clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- data_in_put  in  1  upstream has a lane this cycle.
- data_in_free  out  1  packer accepts a lane this cycle.
- data_in  in  INPUT_WIDTH  lane data.
- flush  in  1  request emission of the current partial word.
- data_out_put  out  1  word valid in output register.
- data_out_free  in  1  downstream consumes word this cycle.
- data_out  out  OUTPUT_WIDTH  word; the first-received lane occupies [INPUT_WIDTH-1:0].
- data_out_count  out  CW  number of valid lanes in data_out, 1..RATIO.

Behaviour:
- Transfers:
  - An input transfer occurs on a cycle where data_in_put && data_in_free.
  - An output transfer occurs on a cycle where data_out_put && data_out_free.
  - Inputs are sampled only on transfer.
- Internal state:
  - acc[OUTPUT_WIDTH-1:0], the accumulator.
  - cnt[CW-1:0] in 0..RATIO, the lane count.
  - flush_pend flag.
  - Output register out_q, out_cnt, out_v.
- slot_ok = !out_v || data_out_free (combinational).
- data_in_free = (cnt != RATIO) && !flush_pend. Combinational from state only; no dependence on data_in_put.
- Lane placement: an accepted lane is written to acc[cnt*INPUT_WIDTH +: INPUT_WIDTH], then cnt increments.
- Word completion:
  - Last-lane accept with slot_ok: the completed word goes straight into out_q at that edge. out_cnt=RATIO, out_v=1, acc/cnt cleared. Latency from last-lane accept to data_out_put is 1 cycle.
  - Last-lane accept without slot_ok: cnt=RATIO and data_in_free drops. The word moves to out_q on the first edge where slot_ok. cnt clears and data_in_free rises the next cycle.
- Output register:
  - An output transfer with no new word clears out_v.
  - An output transfer with a new word loaded the same edge keeps out_v=1, giving back-to-back words with no bubble.
- Flush:
  - flush sampled high with cnt>0, or with a lane accepted the same cycle: sets flush_pend. A same-cycle lane is included in the flushed word.
  - Pending flush: on the first edge with slot_ok, the partial word is moved to out_q. Unfilled upper lanes are zero. out_cnt = cnt. acc/cnt/flush_pend are cleared.
  - flush with cnt==0 and no accept is ignored. No empty word is ever emitted.
  - flush on the same edge that the last lane completes a full word is treated as a normal full word; flush_pend stays 0.
- Reset (reset==0, any time, including mid-word):
  - acc=0, cnt=0, flush_pend=0, out_v=0, out_q=0, out_cnt=0.
  - Partial data is discarded.
  - Outputs: data_out_put=0, data_out=0, data_out_count=0, data_in_free=1.
- Throughput: sustains one lane per cycle indefinitely when data_out_free is held high.
- No combinational path from data_out_free to data_in_free.

Decomposition:
- Shared serial package holds:
  - Handshake naming constants.
  - A ratio/width check function.
  - CW computation, a clog2 helper reused by the serializer.
- One natural sub-module: width_packer_out_reg, the single-entry output holding register with put/free handshake. It is reusable as the serializer's output stage.

Test Plan:
- Defaults (1→8): send bits 1,0,1,1,0,0,1,0 back-to-back with data_out_free=1 → one word 0x4D, count=8, data_out_put high exactly one cycle after the 8th bit.
- 2→8, data_out_free=0, stream 8 lanes of 2'b11 → first word 0xFF held; data_in_free drops after lane 8. On release, second word 0xFF follows with no bubble.
- 1→8 partial flush: bits 1,1,1 then flush → word 0x07, count=3. flush with cnt=0 produces nothing.
- 4→8 flush concurrent with lane accept: lane 0xA, then lane 0x5 with flush high → word 0x5A, count=2, flush_pend cleared.
- Assert reset (0) mid-word after 5 of 8 bits → all outputs at reset values. The next 8 bits 0xFF yield exactly 0xFF, with no residue.
- Randomised put/free stall stress, 1→8 and 2→16 → output stream equals packed input stream, with no loss or duplication.
